// File: rtl/uart_chan_ctrl_pkg.sv
// Shared definitions for the block-transfer channel
// controller that drives the uart64 word UART.
package uart_chan_ctrl_pkg;

  localparam int AW_DEF = 22;
  localparam int DW_DEF = 64;

  localparam logic [3:0] CVL_MAX = 4'd8;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_O_MRD  = 4'd1;
  localparam logic [3:0] S_O_UWR  = 4'd2;
  localparam logic [3:0] S_O_UHI  = 4'd3;
  localparam logic [3:0] S_O_ULO  = 4'd4;
  localparam logic [3:0] S_I_WAIT = 4'd5;
  localparam logic [3:0] S_I_MWR  = 4'd6;
  localparam logic [3:0] S_ADV    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  function automatic logic [3:0] cvl_sat(
    input logic [3:0] v
  );
    return (v > CVL_MAX) ? CVL_MAX : v;
  endfunction

endpackage

// File: rtl/uart_chan_ctrl_addr_unit.sv
// Channel address/limit registers with a wrapping
// incrementer and the end-of-block compare.
module chan_addr_unit
  import uart_chan_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_ca,
  input  logic          load_cl,
  input  logic          inc,
  input  logic [AW-1:0] addr,
  output logic [AW-1:0] ca,
  output logic          last
);

  logic [AW-1:0] cl;
  logic [AW-1:0] ca_nxt;

  // natural AW-bit wrap takes 2^AW-1 back to 0
  assign ca_nxt = ca + AW'(1);
  assign last   = (ca_nxt == cl);

  // CA: CPU load has priority over the advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ca <= '0;
    else if (load_ca)
      ca <= addr;
    else if (inc)
      ca <= ca_nxt;
  end

  // CL: written only when a transfer is armed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cl <= '0;
    else if (load_cl)
      cl <= addr;
  end

endmodule

// File: rtl/uart_chan_ctrl.sv
// Channel controller: moves words between memory and
// uart64 from CA up to CL, then raises chan_int.
module uart_chan_ctrl
  import uart_chan_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_ca_wr,
  input  logic          cpu_cl_wr,
  input  logic          cpu_dir,
  input  logic          cpu_cvl_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [3:0]    cpu_cvl,
  input  logic          cpu_abort,
  input  logic          cpu_int_clr,
  output logic [AW-1:0] ca_out,
  output logic          chan_busy,
  output logic          chan_int,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          u_enable_write,
  output logic          u_enable_read,
  output logic [DW-1:0] u_data_in,
  input  logic [DW-1:0] u_data_out,
  input  logic          u_busy_write,
  input  logic          u_data_avail,
  output logic [3:0]    u_command,
  output logic          u_write_txc,
  output logic          u_write_rxc
);

  logic [3:0]    state;
  logic [3:0]    state_nxt;
  logic          dir;
  logic          abort_pend;
  logic [AW-1:0] ca;
  logic          last;
  logic          idle;
  logic          cl_acc;
  logic          zero_len;
  logic          start;
  logic          kill;
  logic          in_mem;
  logic          inc;

  assign idle     = (state == S_IDLE);
  assign cl_acc   = idle && cpu_cl_wr;
  assign zero_len = cl_acc && (cpu_addr == ca);
  assign start    = cl_acc && !zero_len;
  assign kill     = cpu_abort || abort_pend;
  assign in_mem   = (state == S_O_MRD) ||
                    (state == S_I_MWR);
  assign inc      = (state == S_ADV) && !cpu_abort;

  chan_addr_unit #(.AW(AW)) u_addr (
    .clk     (clk),
    .rst     (rst),
    .load_ca (idle && cpu_ca_wr),
    .load_cl (cl_acc),
    .inc     (inc),
    .addr    (cpu_addr),
    .ca      (ca),
    .last    (last)
  );

  assign ca_out    = ca;
  assign chan_busy = !idle;
  assign mem_req   = in_mem;
  assign mem_we    = (state == S_I_MWR);
  assign mem_addr  = ca;

  // next state; an abort with a request in flight
  // waits for the ack so the bus is never left hanging
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (start)
          state_nxt = cpu_dir ? S_I_WAIT : S_O_MRD;
      S_O_MRD:
        if (mem_ack)
          state_nxt = kill ? S_IDLE : S_O_UWR;
      S_O_UWR:
        if (cpu_abort)
          state_nxt = S_IDLE;
        else if (!u_busy_write)
          state_nxt = S_O_UHI;
      S_O_UHI:
        if (cpu_abort)
          state_nxt = S_IDLE;
        else if (u_busy_write)
          state_nxt = S_O_ULO;
      S_O_ULO:
        if (cpu_abort)
          state_nxt = S_IDLE;
        else if (!u_busy_write)
          state_nxt = S_ADV;
      S_I_WAIT:
        if (cpu_abort)
          state_nxt = S_IDLE;
        else if (u_data_avail)
          state_nxt = S_I_MWR;
      S_I_MWR:
        if (mem_ack)
          state_nxt = kill ? S_IDLE : S_ADV;
      S_ADV:
        if (cpu_abort)
          state_nxt = S_IDLE;
        else if (last)
          state_nxt = S_DONE;
        else
          state_nxt = dir ? S_I_WAIT : S_O_MRD;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // direction latched when a transfer is armed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dir <= 1'b0;
    else if (cl_acc)
      dir <= cpu_dir;
  end

  // remembers an abort seen while waiting on memory
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      abort_pend <= 1'b0;
    else if (state_nxt == S_IDLE)
      abort_pend <= 1'b0;
    else if (cpu_abort && in_mem)
      abort_pend <= 1'b1;
  end

  // outbound word; aborted reads are dropped here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      u_data_in <= '0;
    else if (state == S_O_MRD && mem_ack && !kill)
      u_data_in <= mem_rdata;
  end

  // single-cycle uart64 write strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      u_enable_write <= 1'b0;
    else
      u_enable_write <= (state == S_O_UWR) &&
                        !cpu_abort && !u_busy_write;
  end

  // inbound capture with its uart64 read strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_enable_read <= 1'b0;
      mem_wdata     <= '0;
    end else begin
      u_enable_read <= 1'b0;
      if (state == S_I_WAIT && !cpu_abort &&
          u_data_avail) begin
        u_enable_read <= 1'b1;
        mem_wdata     <= u_data_out;
      end
    end
  end

  // CVL command, programmed for TX and RX together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_command   <= 4'd0;
      u_write_txc <= 1'b0;
      u_write_rxc <= 1'b0;
    end else begin
      u_write_txc <= idle && cpu_cvl_wr;
      u_write_rxc <= idle && cpu_cvl_wr;
      if (idle && cpu_cvl_wr)
        u_command <= cvl_sat(cpu_cvl);
    end
  end

  // sticky done flag; a new set beats a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      chan_int <= 1'b0;
    else if (zero_len || state == S_DONE)
      chan_int <= 1'b1;
    else if (cpu_int_clr)
      chan_int <= 1'b0;
  end

endmodule

// File: tb/tb_uart_chan_ctrl.sv
// Scoreboard bench for uart_chan_ctrl with memory
// and uart64 behavioural responders.
module tb_uart_chan_ctrl;

  localparam int AW = 22;
  localparam int DW = 64;

  localparam int EV_MRD = 0;
  localparam int EV_UWR = 1;
  localparam int EV_URD = 2;
  localparam int EV_MWR = 3;

  typedef struct {
    int          kind;
    logic [21:0] addr;
    logic [63:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_ca_wr, cpu_cl_wr, cpu_dir;
  logic          cpu_cvl_wr, cpu_abort, cpu_int_clr;
  logic [AW-1:0] cpu_addr;
  logic [3:0]    cpu_cvl;
  logic [AW-1:0] ca_out;
  logic          chan_busy, chan_int;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          u_enable_write, u_enable_read;
  logic [DW-1:0] u_data_in, u_data_out;
  logic          u_busy_write, u_data_avail;
  logic [3:0]    u_command;
  logic          u_write_txc, u_write_rxc;

  int   errors = 0;
  int   checks = 0;
  ev_t  sb[$];
  logic [63:0] rx_q[$];

  uart_chan_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_ca_wr      (cpu_ca_wr),
    .cpu_cl_wr      (cpu_cl_wr),
    .cpu_dir        (cpu_dir),
    .cpu_cvl_wr     (cpu_cvl_wr),
    .cpu_addr       (cpu_addr),
    .cpu_cvl        (cpu_cvl),
    .cpu_abort      (cpu_abort),
    .cpu_int_clr    (cpu_int_clr),
    .ca_out         (ca_out),
    .chan_busy      (chan_busy),
    .chan_int       (chan_int),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .u_enable_write (u_enable_write),
    .u_enable_read  (u_enable_read),
    .u_data_in      (u_data_in),
    .u_data_out     (u_data_out),
    .u_busy_write   (u_busy_write),
    .u_data_avail   (u_data_avail),
    .u_command      (u_command),
    .u_write_txc    (u_write_txc),
    .u_write_rxc    (u_write_rxc)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rd(
    input logic [21:0] a
  );
    return {10'h2A5, a, 10'h15A, a};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input int k,
                      input logic [21:0] a,
                      input logic [63:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input int k,
                         input logic [21:0] a,
                         input logic [63:0] d);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind %0d addr %h data %h want none",
               k, a, d);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.addr !== a || e.data !== d) begin
        errors++;
        $display("FAIL sb_event: got k%0d a%h d%h want k%0d a%h d%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // monitor: one scoreboard pop per observed transaction
  always @(negedge clk) begin
    if (rst) begin
      if (mem_req && mem_ack) begin
        if (mem_we)
          pop_chk(EV_MWR, mem_addr, mem_wdata);
        else
          pop_chk(EV_MRD, mem_addr, 64'd0);
      end
      if (u_enable_write)
        pop_chk(EV_UWR, 22'd0, u_data_in);
      if (u_enable_read)
        pop_chk(EV_URD, 22'd0, mem_wdata);
    end
  end

  // memory: ack two cycles into a request
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_req) begin
        cnt++;
        if (cnt >= 2) begin
          mem_ack = 1'b1;
          mem_rdata = mem_we ? 64'd0 : rd(mem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // uart64: busy two cycles after a write, rx fifo
  initial begin
    int bw;
    bw = 0;
    u_busy_write = 1'b0;
    u_data_avail = 1'b0;
    u_data_out = '0;
    forever begin
      @(posedge clk); #1;
      if (u_enable_write)
        bw = 1;
      else if (bw > 0)
        bw++;
      u_busy_write = (bw >= 3 && bw <= 6);
      if (bw >= 7)
        bw = 0;
      if (u_enable_read && rx_q.size() > 0)
        void'(rx_q.pop_front());
      u_data_avail = (rx_q.size() > 0);
      u_data_out = (rx_q.size() > 0) ? rx_q[0] : 64'd0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic prog(input logic [21:0] a,
                      input logic [21:0] l,
                      input logic d);
    cpu_ca_wr = 1'b1;
    cpu_addr = a;
    tick();
    cpu_ca_wr = 1'b0;
    cpu_cl_wr = 1'b1;
    cpu_dir = d;
    cpu_addr = l;
    tick();
    cpu_cl_wr = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (chan_busy && n < 400) begin
      tick();
      n++;
    end
    chk(nm, 64'(chan_busy), 64'd0);
  endtask

  task automatic cvl(input logic [3:0] v);
    cpu_cvl = v;
    cpu_cvl_wr = 1'b1;
    tick();
    cpu_cvl_wr = 1'b0;
  endtask

  task automatic int_clr();
    cpu_int_clr = 1'b1;
    tick();
    cpu_int_clr = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    cpu_ca_wr = 0; cpu_cl_wr = 0; cpu_dir = 0;
    cpu_cvl_wr = 0; cpu_abort = 0; cpu_int_clr = 0;
    cpu_addr = '0; cpu_cvl = '0;
    repeat (3) tick();
    chk("reset_outs",
        64'({ca_out, chan_busy, chan_int, mem_req,
             mem_we, mem_addr, u_enable_write,
             u_enable_read, u_command, u_write_txc,
             u_write_rxc}), 64'd0);
    chk("reset_data", mem_wdata | u_data_in, 64'd0);
    rst = 1'b1;
    tick();

    // 1: output block of three words
    cvl(4'd8);
    chk("cvl8_cmd", 64'(u_command), 64'd8);
    chk("cvl8_txc", 64'({u_write_txc, u_write_rxc}), 64'd3);
    tick();
    chk("cvl8_pulse_end",
        64'({u_write_txc, u_write_rxc}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      push(EV_MRD, 22'(22'h100 + i), 64'd0);
      push(EV_UWR, 22'd0, rd(22'(22'h100 + i)));
    end
    prog(22'h100, 22'h103, 1'b0);
    chk("t1_busy", 64'(chan_busy), 64'd1);
    cvl(4'd5);
    chk("cvl_busy_ignored", 64'(u_command), 64'd8);
    chk("cvl_busy_nopulse", 64'(u_write_txc), 64'd0);
    wait_idle("t1_timeout");
    chk("t1_ca", 64'(ca_out), 64'h103);
    chk("t1_int", 64'(chan_int), 64'd1);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);
    int_clr();
    chk("int_clr", 64'(chan_int), 64'd0);

    // 2: input block of two words
    rx_q.push_back(64'hA1A2A3A4A5A6A7A8);
    rx_q.push_back(64'hB1B2B3B4B5B6B7B8);
    push(EV_URD, 22'd0, 64'hA1A2A3A4A5A6A7A8);
    push(EV_MWR, 22'h20, 64'hA1A2A3A4A5A6A7A8);
    push(EV_URD, 22'd0, 64'hB1B2B3B4B5B6B7B8);
    push(EV_MWR, 22'h21, 64'hB1B2B3B4B5B6B7B8);
    prog(22'h20, 22'h22, 1'b1);
    wait_idle("t2_timeout");
    chk("t2_ca", 64'(ca_out), 64'h22);
    chk("t2_int", 64'(chan_int), 64'd1);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    int_clr();

    // 3: zero-length block
    prog(22'h55, 22'h55, 1'b0);
    chk("t3_int", 64'(chan_int), 64'd1);
    chk("t3_busy", 64'(chan_busy), 64'd0);
    repeat (4) tick();
    chk("t3_busy_later", 64'(chan_busy), 64'd0);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);
    int_clr();

    // 4: wrap through the top of the address space
    push(EV_MRD, 22'h3FFFFF, 64'd0);
    push(EV_UWR, 22'd0, rd(22'h3FFFFF));
    push(EV_MRD, 22'h000000, 64'd0);
    push(EV_UWR, 22'd0, rd(22'h000000));
    prog(22'h3FFFFF, 22'h000001, 1'b0);
    wait_idle("t4_timeout");
    chk("t4_ca", 64'(ca_out), 64'h1);
    chk("t4_int", 64'(chan_int), 64'd1);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);
    int_clr();

    // 5: abort with a read outstanding
    push(EV_MRD, 22'h40, 64'd0);
    prog(22'h40, 22'h44, 1'b0);
    chk("t5_req", 64'(mem_req), 64'd1);
    cpu_abort = 1'b1;
    tick();
    cpu_abort = 1'b0;
    wait_idle("t5_timeout");
    repeat (12) tick();
    chk("t5_int", 64'(chan_int), 64'd0);
    chk("t5_ca", 64'(ca_out), 64'h40);
    chk("t5_discard", u_data_in, rd(22'h0));
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);
    cpu_ca_wr = 1'b1;
    cpu_addr = 22'h40;
    tick();
    cpu_ca_wr = 1'b0;
    cpu_cl_wr = 1'b1;
    cpu_int_clr = 1'b1;
    tick();
    cpu_cl_wr = 1'b0;
    cpu_int_clr = 1'b0;
    chk("t5_set_wins", 64'(chan_int), 64'd1);
    int_clr();

    // 6: async reset while waiting in O_ULO
    push(EV_MRD, 22'h10, 64'd0);
    push(EV_UWR, 22'd0, rd(22'h10));
    prog(22'h10, 22'h12, 1'b0);
    n = 0;
    while (!u_busy_write && n < 100) begin
      tick();
      n++;
    end
    chk("t6_busy_seen", 64'(u_busy_write), 64'd1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("t6_async_outs",
        64'({ca_out, chan_busy, chan_int, mem_req,
             mem_we, mem_addr, u_enable_write,
             u_enable_read, u_command, u_write_txc,
             u_write_rxc}), 64'd0);
    chk("t6_async_data", mem_wdata | u_data_in, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) tick();
    chk("t6_idle", 64'(chan_busy), 64'd0);
    chk("t6_sb_empty", 64'(sb.size()), 64'd0);
    cvl(4'd3);
    chk("t6_cmd", 64'(u_command), 64'd3);
    chk("t6_txc_rxc", 64'({u_write_txc, u_write_rxc}), 64'd3);
    tick();
    chk("t6_pulse_end",
        64'({u_write_txc, u_write_rxc}), 64'd0);
    cvl(4'd12);
    chk("cvl_saturate", 64'(u_command), 64'd8);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_chan_ctrl.md
Name: uart_chan_ctrl

Overview:
Cray-style I/O channel controller that sequences the 64-bit word UART, uart64, as a block-transfer channel.
- The CPU programs a Channel Address (CA), a Channel Limit (CL), a direction and a Character Vector Length (CVL).
- The controller moves words between central memory and uart64 without CPU involvement.
- It raises a channel-done interrupt when CA reaches CL.

Parameters:
AW, 22, memory word address width (CA/CL width)
DW, 64, data word width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous reset, active-low (asserted when 0)
cpu_ca_wr  in  1  load CA from cpu_addr
cpu_cl_wr  in  1  load CL from cpu_addr; starts transfer
cpu_dir  in  1  sampled with cpu_cl_wr: 0 = output (mem->uart), 1 = input (uart->mem)
cpu_cvl_wr  in  1  load CVL and program uart64 command
cpu_addr  in  AW  CA/CL value
cpu_cvl  in  4  CVL value 0..8
cpu_abort  in  1  terminate active transfer
cpu_int_clr  in  1  clear done interrupt
ca_out  out  AW  current CA (CPU-readable)
chan_busy  out  1  transfer in progress
chan_int  out  1  channel-done interrupt (sticky)
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  AW  = CA
mem_wdata  out  DW  word received from UART
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle acknowledge
u_enable_write  out  1  one-cycle pulse to uart64 enable_write
u_enable_read  out  1  one-cycle pulse to uart64 enable_read
u_data_in  out  DW  word to uart64
u_data_out  in  DW  word from uart64
u_busy_write  in  1  uart64 busy_write
u_data_avail  in  1  uart64 data_avail
u_command  out  4  CVL to uart64 command
u_write_txc  out  1  pulse: latch TX CVL
u_write_rxc  out  1  pulse: latch RX CVL

Behaviour:
- Reset values: all outputs 0; CA = CL = 0; state IDLE.
- CVL write: cpu_cvl_wr registers cpu_cvl into u_command and pulses u_write_txc and u_write_rxc together on the next cycle.
  - cpu_cvl values above 8 saturate to 8.
  - CVL writes are accepted only in IDLE; while busy they are ignored.
- CA/CL writes:
  - cpu_ca_wr is accepted only in IDLE.
  - cpu_cl_wr in IDLE loads CL and dir.
    - If the new CL equals CA: zero-length transfer; chan_int sets the next cycle and the FSM stays in IDLE.
    - Otherwise the FSM leaves IDLE the next cycle.
  - cpu_cl_wr while busy is ignored.
- States:
  - IDLE.
  - O_MRD: mem_req=1, mem_we=0; on mem_ack latch mem_rdata into u_data_in -> O_UWR.
  - O_UWR: when u_busy_write=0, pulse u_enable_write for 1 cycle -> O_UHI.
  - O_UHI: wait u_busy_write=1 (uart64 asserts it 2 cycles after the enable) -> O_ULO.
  - O_ULO: wait u_busy_write=0 -> ADV.
  - I_WAIT: wait u_data_avail=1; capture u_data_out into mem_wdata and pulse u_enable_read -> I_MWR.
  - I_MWR: mem_req=1, mem_we=1; hold until mem_ack -> ADV.
  - ADV: CA <= CA+1, mod 2^AW (wraps 2^AW-1 -> 0). If CA+1 == CL -> DONE, else O_MRD or I_WAIT according to the latched dir.
  - DONE: set chan_int and clear chan_busy -> IDLE.
- chan_busy = (state != IDLE).
- mem_req drops the cycle after mem_ack; mem_addr is stable for the whole request.
- One word per iteration.
  - Output throughput is bounded by the UART.
  - The memory request for word n+1 is not issued until word n has left uart64 (no prefetch).
- cpu_abort while busy:
  - If a memory request is outstanding, it completes; the ack is consumed and the data discarded.
  - Then the FSM goes to IDLE, CA is not incremented, and chan_int is not set.
  - In IDLE, cpu_abort has no effect.
- chan_int is sticky until cpu_int_clr.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around: CL < CA is legal; the transfer runs through 2^AW-1 and 0 up to CL.
- Asynchronous reset mid-transfer:
  - All state is cleared immediately, with no memory write completion.
  - The external memory must tolerate a dropped request.

Decomposition:
- Shared package (Cray_VI_construction scope): channel FSM state encodings, the CVL maximum constant (8), and the AW/DW defaults.
- One natural sub-module, chan_addr_unit: the CA/CL registers, incrementer with wrap, and the equality compare. Its interface is load_ca, load_cl, inc, ca, last.

Test Plan:
1. CVL=8, CA=0x100, CL=0x103, dir=0, memory holds distinct words -> three u_enable_write pulses carrying mem[0x100..0x102] in order; CA ends at 0x103; chan_int=1.
2. dir=1, CA=0x20, CL=0x22, uart64 model delivers 0xA1A2..A8 then 0xB1..B8 -> memory writes at 0x20 and 0x21 with those words; u_enable_read pulsed twice; chan_int=1.
3. CA=CL=0x55, cpu_cl_wr -> no mem_req; chan_int=1 the next cycle; chan_busy stays 0.
4. CA=0x3FFFFF, CL=0x000001, dir=0 -> reads at 0x3FFFFF and 0x000000; CA ends at 1.
5. cpu_abort asserted while mem_req is pending in O_MRD -> ack consumed, no u_enable_write, IDLE, chan_int=0, CA unchanged. Then cpu_int_clr together with a done event -> chan_int remains 1.
6. rst driven low in O_ULO -> all outputs 0 asynchronously; after release, cpu_cvl_wr=3 -> u_command=3 with single-cycle u_write_txc and u_write_rxc pulses.
